rob_issue_scheduler: RTL

- Out-of-order issue scheduler between ROB dispatch and the ROB-to-issue pipeline register.
- Tracks operand readiness of every in-flight ROB entry and wakes entries on writeback broadcast.
- Each cycle, selects the oldest fully-ready entry relative to the ROB head and presents its ROB address plus a can-issue flag to the ROB-to-issue register.
- Honours downstream stall and global flush.

---
 rtl/rob_issue_scheduler_pkg.sv | 20 ++
 rtl/rob_age_select.sv | 39 +++
 rtl/rob_issue_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rob_issue_scheduler_pkg.sv
// Purpose : shared types for the ROB issue scheduler and its age picker.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package rob_issue_scheduler_pkg;

  // Default ROB index width; the table holds 2**width entries.
  localparam int ROB_ADDR_WIDTH_DEF = 4;

  // Output-slot FSM: RUN selects every unstalled cycle, HOLD parks a
  // valid issue slot while downstream is stalled.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  function automatic int rob_size(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rob_age_select.sv
// Purpose : rotating-priority picker, returns the first set bit at or after i_head (wrapping).
// Latency : purely combinational.
// Backpressure: none; caller decides whether to consume the pick.
//
// Ports:
//   i_eligible  per-entry request vector
//   i_head      age origin; offset 0 is the oldest
//   o_found     at least one request is set
//   o_index     index of the oldest request (0 when none)
module rob_age_select
  import rob_issue_scheduler_pkg::*;
#(
  parameter int ADDR_W = ROB_ADDR_WIDTH_DEF
) (
  input  logic [(1<<ADDR_W)-1:0] i_eligible,
  input  logic [ADDR_W-1:0]      i_head,
  output logic                   o_found,
  output logic [ADDR_W-1:0]      o_index
);

  localparam int N = rob_size(ADDR_W);

  logic [ADDR_W-1:0] w_idx;

  // Scan youngest-to-oldest so the last hit written is the oldest one.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = i_head + ADDR_W'(i);
      if (i_eligible[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/rob_issue_scheduler.sv
// Purpose : out-of-order issue scheduler; tracks operand readiness per ROB entry, picks oldest ready.
// Latency : alloc (both ready) or wakeup in cycle n -> o_can_issue earliest in cycle n+2.
// Backpressure: i_stall_next_stage freezes the output slot; a valid slot is parked in HOLD.
//
// Ports:
//   i_clk, i_rst (async active-low), i_flush (sync), i_stall_next_stage
//   i_rob_head                          age origin for selection
//   i_alloc_en/addr/rdy_1/rdy_2/tag_1/tag_2   dispatch write
//   i_wb_en/i_wb_addr                   writeback broadcast
//   o_can_issue/o_issue_rob_addr        registered issue slot
//   o_pending_count                     valid entries in the table
//   o_alloc_conflict                    sticky: alloc hit a valid entry
module rob_issue_scheduler
  import rob_issue_scheduler_pkg::*;
#(
  parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic                      i_stall_next_stage,
  input  logic [ROB_ADDR_WIDTH-1:0] i_rob_head,
  input  logic                      i_alloc_en,
  input  logic [ROB_ADDR_WIDTH-1:0] i_alloc_addr,
  input  logic                      i_alloc_rdy_1,
  input  logic                      i_alloc_rdy_2,
  input  logic [ROB_ADDR_WIDTH-1:0] i_alloc_tag_1,
  input  logic [ROB_ADDR_WIDTH-1:0] i_alloc_tag_2,
  input  logic                      i_wb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] i_wb_addr,
  output logic                      o_can_issue,
  output logic [ROB_ADDR_WIDTH-1:0] o_issue_rob_addr,
  output logic [ROB_ADDR_WIDTH:0]   o_pending_count,
  output logic                      o_alloc_conflict
);

  localparam int ROB_SIZE = rob_size(ROB_ADDR_WIDTH);

  // Entry table
  logic [ROB_SIZE-1:0]       r_valid;
  logic [ROB_SIZE-1:0]       r_rdy1;
  logic [ROB_SIZE-1:0]       r_rdy2;
  logic [ROB_ADDR_WIDTH-1:0] r_tag1 [ROB_SIZE];
  logic [ROB_ADDR_WIDTH-1:0] r_tag2 [ROB_SIZE];

  // Output slot, FSM, counters
  sched_state_e              r_state;
  sched_state_e              w_state_nxt;
  logic                      r_can_issue;
  logic [ROB_ADDR_WIDTH-1:0] r_issue_addr;
  logic [ROB_ADDR_WIDTH:0]   r_pending;
  logic                      r_conflict;

  logic [ROB_SIZE-1:0]       w_eligible;
  logic                      w_found;
  logic [ROB_ADDR_WIDTH-1:0] w_pick;
  logic                      w_load;
  logic                      w_remove;
  logic [ROB_SIZE-1:0]       w_alloc_oh;
  logic [ROB_SIZE-1:0]       w_remove_oh;
  logic [ROB_SIZE-1:0]       w_wake1;
  logic [ROB_SIZE-1:0]       w_wake2;
  logic                      w_alloc_rdy1;
  logic                      w_alloc_rdy2;
  logic                      w_inc;
  logic                      w_dec;

  assign w_eligible = r_valid & r_rdy1 & r_rdy2;

  rob_age_select #(
    .ADDR_W (ROB_ADDR_WIDTH)
  ) u_age_select (
    .i_eligible (w_eligible),
    .i_head     (i_rob_head),
    .o_found    (w_found),
    .o_index    (w_pick)
  );

  // FSM next state; w_load marks a cycle in which the output slot reloads.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!i_stall_next_stage) begin
          w_load = 1'b1;
        end else if (r_can_issue) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!i_stall_next_stage) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_remove    = w_load & w_found;
  assign w_alloc_oh  = i_alloc_en ? (ROB_SIZE'(1) << i_alloc_addr) : '0;
  assign w_remove_oh = w_remove ? (ROB_SIZE'(1) << w_pick) : '0;

  // Same-cycle writeback bypass into a fresh allocation.
  assign w_alloc_rdy1 = i_alloc_rdy_1 | (i_wb_en && (i_wb_addr == i_alloc_tag_1));
  assign w_alloc_rdy2 = i_alloc_rdy_2 | (i_wb_en && (i_wb_addr == i_alloc_tag_2));

  always_comb begin
    w_wake1 = '0;
    w_wake2 = '0;
    for (int e = 0; e < ROB_SIZE; e++) begin
      w_wake1[e] = i_wb_en && r_valid[e] && (r_tag1[e] == i_wb_addr);
      w_wake2[e] = i_wb_en && r_valid[e] && (r_tag2[e] == i_wb_addr);
    end
  end

  // A re-allocation of the slot being issued keeps it occupied, so the
  // removal does not count against the total in that case.
  assign w_inc = i_alloc_en & ~r_valid[i_alloc_addr];
  assign w_dec = w_remove & ~(i_alloc_en && (i_alloc_addr == w_pick));

  // Entry table: allocation wins over removal/wakeup for the same slot.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      for (int e = 0; e < ROB_SIZE; e++) begin
        r_tag1[e] <= '0;
        r_tag2[e] <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      for (int e = 0; e < ROB_SIZE; e++) begin
        if (w_alloc_oh[e]) begin
          r_valid[e] <= 1'b1;
          r_rdy1[e]  <= w_alloc_rdy1;
          r_rdy2[e]  <= w_alloc_rdy2;
          r_tag1[e]  <= i_alloc_tag_1;
          r_tag2[e]  <= i_alloc_tag_2;
        end else begin
          if (w_remove_oh[e]) r_valid[e] <= 1'b0;
          if (w_wake1[e])     r_rdy1[e]  <= 1'b1;
          if (w_wake2[e])     r_rdy2[e]  <= 1'b1;
        end
      end
    end
  end

  // Output slot and FSM state
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_RUN;
      r_can_issue  <= 1'b0;
      r_issue_addr <= '0;
    end else if (i_flush) begin
      r_state      <= ST_RUN;
      r_can_issue  <= 1'b0;
      r_issue_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_can_issue  <= w_found;
        r_issue_addr <= w_found ? w_pick : '0;
      end
    end
  end

  // Occupancy counter and sticky conflict flag (flush leaves the flag alone)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pending  <= '0;
      r_conflict <= 1'b0;
    end else if (i_flush) begin
      r_pending <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
      if (i_alloc_en && r_valid[i_alloc_addr]) r_conflict <= 1'b1;
    end
  end

  assign o_can_issue      = r_can_issue;
  assign o_issue_rob_addr = r_issue_addr;
  assign o_pending_count  = r_pending;
  assign o_alloc_conflict = r_conflict;

endmodule
